// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory controller.
// Parity storage is enabled by defining DATA_MEM_PARITY_EN.
package data_mem_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned BE_W       = DEF_DATA_W / 8;

    // Even parity: stored bit makes the byte plus parity an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage: byte-enable synchronous write, registered read.
// Per-byte parity bits are kept when DATA_MEM_PARITY_EN is defined.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                perr_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

`ifdef DATA_MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic          perr_q;
    logic          perr_now;

    always_comb begin
        perr_now = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (byte_parity(mem_q[addr_i][8*b +: 8]) != par_q[addr_i][b]) perr_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_i[b]) par_q[addr_i][b] <= byte_parity(wdata_i[8*b +: 8]);
            end
        end
        if (re_i) perr_q <= perr_now;
    end

    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// Valid/ready data memory controller: post-reset clear sweep, range check,
// single response slot. Define DATA_MEM_PARITY_EN for per-byte parity checking.
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                oor_q, oor_d;

    logic                mem_we, mem_re;
    logic [AW-1:0]       mem_addr;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_perr;
    logic                in_range;
    logic                accept;

    // Full-width compare so high address bits never alias onto a legal word.
    assign in_range  = (req_addr < ADDR_W'(DEPTH));
    assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        oor_d       = oor_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = req_addr[AW-1:0];
        mem_be      = req_be;
        mem_wdata   = req_wdata;
        busy        = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_be    = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
                if (accept) begin
                    if (req_wr) begin
                        mem_we = in_range;
                    end else begin
                        rsp_valid_d = 1'b1;
                        oor_d       = !in_range;
                        mem_re      = in_range;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            oor_q       <= oor_d;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .be_i    (mem_be),
        .wdata_i (mem_wdata),
        .rdata_o (arr_rdata),
        .perr_o  (arr_perr)
    );

    // The read register only loads on in-range reads; gating keeps the slot
    // output zero on reset and on range errors.
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = (rsp_valid_q && !oor_q) ? arr_rdata : '0;
    assign rsp_err   = rsp_valid_q && (oor_q || arr_perr);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (DEPTH=16) with a transaction-level model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DATA_W (32),
        .ADDR_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Model: memory contents, remaining clear cycles, one expected response.
    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    int          m_clr = DEPTH;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_err = 1'b0;
    bit          m_acc;

    function automatic bit model_ready();
        return (m_clr == 0) && (!m_valid || rsp_ready);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_clr   = DEPTH;
            m_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_bad[i] = 1'b0;
            end
        end else if (m_clr > 0) begin
            m_clr = m_clr - 1;
        end else begin
            m_acc = req_valid && (!m_valid || rsp_ready);
            if (m_valid && rsp_ready) m_valid = 1'b0;
            if (m_acc) begin
                if (req_wr) begin
                    if (req_addr < DEPTH) begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) m_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                        if (req_be != 4'b0000) m_bad[req_addr] = 1'b0;
                    end
                end else begin
                    m_valid = 1'b1;
                    if (req_addr < DEPTH) begin
                        m_data = m_mem[req_addr];
                        m_err  = m_bad[req_addr];
                    end else begin
                        m_data = '0;
                        m_err  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_clr > 0));
            chk("req_ready", 32'(req_ready), 32'(model_ready()));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rsp_rdata", rsp_rdata, m_data);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    // Entered at negedge+1 with a request driven; returns at negedge+1 after acceptance.
    task automatic wait_acc();
        int k = 0;
        while (!model_ready() && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept want accept at %0t", $time);
        end
        @(negedge clk); #1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_be = be; req_wdata = d;
        wait_acc();
    endtask

    task automatic rd(input logic [31:0] a);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_be = 4'b0000;
        wait_acc();
    endtask

    task automatic wait_clear();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 100) begin
            total++;
            bad++;
            $display("FAIL clear_timeout: got busy=1 want busy=0 at %0t", $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_be = '0; req_wdata = '0; rsp_ready = 1'b1;

        // 1: reset state, clear length, all-zero contents
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        #1 rst = 1'b0;
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk("clear_len", 32'(n), 32'd16);
        #1;
        for (int i = 0; i < DEPTH; i++) rd(32'(i));

        // 2: full write then byte-lane merge
        wr(32'd5, 4'b1111, 32'hDEADBEEF);
        wr(32'd5, 4'b0001, 32'h000000AA);
        rd(32'd5);
        chk("t2_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rdata", rsp_rdata, 32'hDEADBEAA);
        wr(32'd6, 4'b0110, 32'h11223344);
        wr(32'd6, 4'b0000, 32'hFFFFFFFF);
        rd(32'd6);
        chk("t2_be_mid", rsp_rdata, 32'h00223300);

        // 3: back-to-back reads, then backpressure
        wr(32'd2, 4'b1111, 32'h22222222);
        wr(32'd3, 4'b1111, 32'h33333333);
        wr(32'd4, 4'b1111, 32'h44444444);
        rd(32'd2); chk("t3_b2b_2", rsp_rdata, 32'h22222222);
        rd(32'd3); chk("t3_b2b_3", rsp_rdata, 32'h33333333);
        rd(32'd4); chk("t3_b2b_4", rsp_rdata, 32'h44444444);
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        rd(32'd2);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_ready", 32'(req_ready), 32'd0);
            chk("t3_hold_data", rsp_rdata, 32'h22222222);
            #1;
        end
        rsp_ready = 1'b1;
        wait_acc();
        chk("t3_after_3", rsp_rdata, 32'h33333333);
        rd(32'd4); chk("t3_after_4", rsp_rdata, 32'h44444444);

        // 4: out-of-range read and write
        wr(32'd15, 4'b1111, 32'h12345678);
        rd(32'd16);
        chk("t4_oor_err", 32'(rsp_err), 32'd1);
        chk("t4_oor_rdata", rsp_rdata, 32'd0);
        wr(32'hFFFF_FFFF, 4'b1111, 32'hCAFEF00D);
        rd(32'd15); chk("t4_no_alias", rsp_rdata, 32'h12345678);
        rd(32'hFFFF_FFFF); chk("t4_top_err", 32'(rsp_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd(32'(i));

        // 5: reset with a response pending
        wr(32'd9, 4'b1111, 32'h99999999);
        rsp_ready = 1'b0;
        rd(32'd9);
        chk("t5_pending", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid_drop", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        wait_clear();
        rd(32'd9); chk("t5_recleared_9", rsp_rdata, 32'd0);
        rd(32'd5); chk("t5_recleared_5", rsp_rdata, 32'd0);

        // 6: parity behaviour on a corrupted word
        wr(32'd7, 4'b1111, 32'hA5A5A5A5);
`ifdef DATA_MEM_PARITY_EN
        force dut.u_array.mem_q[7] = 32'hA5A5A5A4;
        m_mem[7] = 32'hA5A5A5A4;
        m_bad[7] = 1'b1;
        rd(32'd7);
        chk("t6_par_err", 32'(rsp_err), 32'd1);
        chk("t6_par_data", rsp_rdata, 32'hA5A5A5A4);
        release dut.u_array.mem_q[7];
`else
        rd(32'd7);
        chk("t6_no_par_err", 32'(rsp_err), 32'd0);
        chk("t6_data", rsp_rdata, 32'hA5A5A5A5);
`endif
        repeat (3) @(negedge clk);
        #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
